r_type_exec_ctrl: RTL and testbench

- Multi-cycle fetch/decode/execute/write-back controller for the R-type CPU.
- Fetches from a combinational instruction ROM and decodes MIPS R-type words.
- Drives the register-file read/write address ports and latches the returned operands.
- Computes the ALU result internally and drives the write-back port. It sits directly upstream of the register file and consumes its read data.

---
 rtl/r_type_exec_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_r_type_exec_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_type_exec_ctrl.sv
// r_type_exec_ctrl: four-cycle fetch/decode/execute/write-back controller for MIPS R-type words.
// Operands come from an external register file; results return through the W_* port.
//
// state | meaning
// IF    | wait for Run, latch instruction word, advance PC
// ID    | latch register operands, reject unsupported words
// EX    | compute ALU result and register ZF/OF
// WB    | present result and write strobe to the register file
module r_type_exec_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        Clka,
    input  logic        Reset,
    input  logic        Run,
    output logic [31:0] Inst_Addr,
    input  logic [31:0] Inst_Data,
    output logic [4:0]  R_Addr_A,
    output logic [4:0]  R_Addr_B,
    input  logic [31:0] R_Data_A,
    input  logic [31:0] R_Data_B,
    output logic [4:0]  W_Addr,
    output logic [31:0] W_Data,
    output logic        Write_Reg,
    output logic        ZF,
    output logic        OF,
    output logic        Illegal,
    output logic        Inst_Done
);

    typedef enum logic [1:0] {S_IF, S_ID, S_EX, S_WB} state_t;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] w_data_q;
    logic        zf_q;
    logic        of_q;

    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic        funct_ok;
    logic        legal;
    logic        is_add_sub;
    logic [31:0] alu_f;
    logic        alu_of;

    assign funct      = ir[5:0];
    assign shamt      = ir[10:6];
    assign is_add_sub = (funct == F_ADD) || (funct == F_SUB);
    assign legal      = (ir[31:26] == 6'd0) && funct_ok;

    assign Inst_Addr = pc;
    assign R_Addr_A  = ir[25:21];
    assign R_Addr_B  = ir[20:16];
    assign W_Addr    = ir[15:11];
    assign W_Data    = w_data_q;
    assign ZF        = zf_q;
    assign OF        = of_q;

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
            F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: funct_ok = 1'b1;
            default:                            funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_f  = '0;
        alu_of = 1'b0;
        case (funct)
            F_ADD, F_ADDU: alu_f = opa + opb;
            F_SUB, F_SUBU: alu_f = opa - opb;
            F_AND:         alu_f = opa & opb;
            F_OR:          alu_f = opa | opb;
            F_XOR:         alu_f = opa ^ opb;
            F_NOR:         alu_f = ~(opa | opb);
            F_SLT:         alu_f = {31'd0, $signed(opa) < $signed(opb)};
            F_SLTU:        alu_f = {31'd0, opa < opb};
            F_SLL:         alu_f = opb << shamt;
            F_SRL:         alu_f = opb >> shamt;
            F_SRA:         alu_f = $unsigned($signed(opb) >>> shamt);
            default:       alu_f = '0;
        endcase
        // Only the trapping forms report overflow; addu/subu wrap silently.
        if (funct == F_ADD) begin
            alu_of = (opa[31] == opb[31]) && (alu_f[31] != opa[31]);
        end else if (funct == F_SUB) begin
            alu_of = (opa[31] != opb[31]) && (alu_f[31] != opa[31]);
        end
    end

    always_comb begin
        state_nxt = state;
        Write_Reg = 1'b0;
        Illegal   = 1'b0;
        Inst_Done = 1'b0;
        case (state)
            S_IF: begin
                if (Run) begin
                    state_nxt = S_ID;
                end
            end
            S_ID: begin
                if (legal) begin
                    state_nxt = S_EX;
                end else begin
                    Illegal   = 1'b1;
                    state_nxt = S_IF;
                end
            end
            S_EX: begin
                state_nxt = S_WB;
            end
            S_WB: begin
                // rd==0 covers the all-zero word (sll $0,$0,0).
                Write_Reg = (ir[15:11] != 5'd0) && !(of_q && is_add_sub);
                Inst_Done = 1'b1;
                state_nxt = S_IF;
            end
            default: begin
                state_nxt = S_IF;
            end
        endcase
    end

    always_ff @(posedge Clka or posedge Reset) begin
        if (Reset) begin
            state    <= S_IF;
            pc       <= PC_RESET;
            ir       <= '0;
            opa      <= '0;
            opb      <= '0;
            w_data_q <= '0;
            zf_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IF: begin
                    if (Run) begin
                        ir <= Inst_Data;
                        pc <= pc + PC_STEP;
                    end
                end
                S_ID: begin
                    opa <= R_Data_A;
                    opb <= R_Data_B;
                end
                S_EX: begin
                    w_data_q <= alu_f;
                    zf_q     <= (alu_f == 32'd0);
                    of_q     <= alu_of;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r_type_exec_ctrl.sv
// Bench for r_type_exec_ctrl: instruction-level reference model, per-cycle compare, directed and random programs.
module tb_r_type_exec_ctrl;

    logic        Clka = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic [31:0] Inst_Addr;
    logic [31:0] Inst_Data;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [31:0] R_Data_A;
    logic [31:0] R_Data_B;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic        ZF;
    logic        OF;
    logic        Illegal;
    logic        Inst_Done;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    logic [31:0] rom [0:63];
    logic [31:0] rf [0:31];
    logic [31:0] mregs [0:31];

    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = 5'd0;
    logic [31:0] ld_val = 32'd0;

    // Reference model state: instruction age since fetch (0 = idle) and the
    // precomputed outcome of the instruction in flight.
    int          m_age = 0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_ir = 32'd0;
    logic        e_ill = 1'b0;
    logic [31:0] e_res = 32'd0;
    logic        e_of = 1'b0;
    logic        e_wr = 1'b0;
    logic [31:0] v_wdata = 32'd0;
    logic        v_zf = 1'b0;
    logic        v_of = 1'b0;

    logic [5:0] legal_f [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03};

    r_type_exec_ctrl #(.PC_RESET(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .Clka(Clka), .Reset(Reset), .Run(Run),
        .Inst_Addr(Inst_Addr), .Inst_Data(Inst_Data),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
        .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
        .ZF(ZF), .OF(OF), .Illegal(Illegal), .Inst_Done(Inst_Done)
    );

    always #5 Clka = ~Clka;

    assign Inst_Data = rom[Inst_Addr[7:2]];
    assign R_Data_A  = (R_Addr_A == 5'd0) ? 32'd0 : rf[R_Addr_A];
    assign R_Data_B  = (R_Addr_B == 5'd0) ? 32'd0 : rf[R_Addr_B];

    function automatic logic is_legal(input logic [31:0] inst);
        logic ok = 1'b0;
        for (int i = 0; i < 13; i++) if (inst[5:0] == legal_f[i]) ok = 1'b1;
        return (inst[31:26] == 6'd0) && ok;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh = inst[10:6];
        logic [31:0] ones = 32'hFFFF_FFFF;
        logic [31:0] fill;
        fill = b[31] ? ~(ones >> sh) : 32'd0;
        case (inst[5:0])
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2a: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            6'h2b: return (a < b) ? 32'd1 : 32'd0;
            6'h00: return b << sh;
            6'h02: return b >> sh;
            6'h03: return (b >> sh) | fill;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        if (inst[5:0] == 6'h20) s = sa + sb;
        else if (inst[5:0] == 6'h22) s = sa - sb;
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluates each instruction as a whole at fetch time.
    initial begin
        for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
        forever begin
            @(posedge Clka or posedge Reset);
            if (Reset) begin
                m_age = 0; m_pc = 32'd0; m_ir = 32'd0;
                v_wdata = 32'd0; v_zf = 1'b0; v_of = 1'b0;
            end else begin
                if (ld_en) mregs[ld_addr] = ld_val;
                case (m_age)
                    0: if (Run) begin
                        m_ir  = rom[m_pc[7:2]];
                        m_pc  = m_pc + 32'd4;
                        e_ill = !is_legal(m_ir);
                        e_res = ref_alu(m_ir, mregs[m_ir[25:21]], mregs[m_ir[20:16]]);
                        e_of  = ref_ovf(m_ir, mregs[m_ir[25:21]], mregs[m_ir[20:16]]);
                        e_wr  = (m_ir[15:11] != 5'd0) && !e_of;
                        m_age = 1;
                    end
                    1: m_age = e_ill ? 0 : 2;
                    2: begin
                        v_wdata = e_res; v_zf = (e_res == 32'd0); v_of = e_of;
                        m_age = 3;
                    end
                    default: begin
                        if (e_wr) mregs[m_ir[15:11]] = e_res;
                        m_age = 0;
                    end
                endcase
            end
        end
    end

    // Register file: writes land on the negedge of the write-back cycle.
    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        forever begin
            @(negedge Clka);
            if (Write_Reg) rf[W_Addr] = W_Data;
            else if (ld_en) rf[ld_addr] = ld_val;
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge Clka);
            if (chk_en) begin
                chk("inst_addr", Inst_Addr, m_pc);
                chk("r_addr_a", 32'(R_Addr_A), 32'(m_ir[25:21]));
                chk("r_addr_b", 32'(R_Addr_B), 32'(m_ir[20:16]));
                chk("w_addr", 32'(W_Addr), 32'(m_ir[15:11]));
                chk("w_data", W_Data, v_wdata);
                chk("zf", 32'(ZF), 32'(v_zf));
                chk("of", 32'(OF), 32'(v_of));
                chk("illegal", 32'(Illegal), 32'(m_age == 1 && e_ill));
                chk("inst_done", 32'(Inst_Done), 32'(m_age == 3));
                chk("write_reg", 32'(Write_Reg), 32'(m_age == 3 && e_wr));
            end
        end
    end

    task automatic set_reg(input logic [4:0] a, input logic [31:0] v);
        ld_addr = a; ld_val = v; ld_en = 1'b1;
        @(posedge Clka);
        @(negedge Clka);
        #1 ld_en = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] inst, output logic done, output logic ill,
                           output logic [31:0] wd, output logic wr, output logic zf,
                           output logic of_f, output logic [4:0] wa);
        bit fin = 0;
        rom[m_pc[7:2]] = inst;
        Run = 1'b1;
        @(posedge Clka);
        #1 Run = 1'b0;
        done = 0; ill = 0; wd = 0; wr = 0; zf = 0; of_f = 0; wa = 0;
        for (int k = 0; k < 6 && !fin; k++) begin
            @(negedge Clka);
            if (Illegal) begin
                ill = 1; wr = Write_Reg; fin = 1;
                if (k != 0) $display("FAIL illegal_latency: got %0d, expected 0", k);
                if (k != 0) errors++;
            end else if (Inst_Done) begin
                done = 1; wd = W_Data; wr = Write_Reg; zf = ZF; of_f = OF; wa = W_Addr; fin = 1;
            end
        end
        chk("run_one_finished", 32'(fin), 32'd1);
        @(posedge Clka);
        #1;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), legal_f[$urandom_range(0, 12)]};
        case ($urandom_range(0, 15))
            0: w[31:26] = 6'($urandom_range(1, 63));
            1: w[5:0] = 6'($urandom_range(0, 63));
            2: w = 32'd0;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        d, il, w, z, o;
        logic [31:0] wd;
        logic [4:0]  wa;
        int          n_done, k_first, wr_pulses;

        for (int i = 0; i < 64; i++) rom[i] = 32'd0;

        // Pin the reference ALU against hand-computed values.
        chk("model_add", ref_alu(32'h0022_1820, 32'd5, 32'd7), 32'd12);
        chk("model_slt", ref_alu(32'h0022_202A, 32'hFFFF_FFFF, 32'd1), 32'd1);
        chk("model_sltu", ref_alu(32'h0022_202B, 32'hFFFF_FFFF, 32'd1), 32'd0);
        chk("model_sra", ref_alu(32'h0001_2903, 32'd0, 32'h8000_0000), 32'hF800_0000);
        chk("model_srl", ref_alu(32'h0001_2902, 32'd0, 32'h8000_0000), 32'h0800_0000);
        chk("model_ovf", 32'(ref_ovf(32'h0022_1820, 32'h7FFF_FFFF, 32'd1)), 32'd1);

        repeat (2) @(posedge Clka);
        #1;
        chk("reset_inst_addr", Inst_Addr, 32'd0);
        chk("reset_outputs", {W_Data[15:0], 11'd0, Write_Reg, ZF, OF, Illegal, Inst_Done}, 32'd0);
        Reset = 1'b0;
        chk_en = 1'b1;

        // Back-to-back add $3,$1,$2 ; add $4,$3,$3
        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd7);
        rom[0] = 32'h0022_1820;
        rom[1] = 32'h0063_2020;
        Run = 1'b1;
        n_done = 0; k_first = 0;
        for (int k = 0; k < 20 && n_done < 2; k++) begin
            @(negedge Clka);
            if (Inst_Done) begin
                n_done++;
                if (n_done == 1) begin
                    k_first = k;
                    chk("add_waddr", 32'(W_Addr), 32'd3);
                    chk("add_wdata", W_Data, 32'd12);
                    chk("add_wr", 32'(Write_Reg), 32'd1);
                    chk("add_flags", {30'd0, ZF, OF}, 32'd0);
                    chk("add_pc", Inst_Addr, 32'd4);
                end else begin
                    chk("raw_wdata", W_Data, 32'd24);
                    chk("raw_waddr", 32'(W_Addr), 32'd4);
                    chk("done_gap", 32'(k - k_first), 32'd4);
                    chk("raw_pc", Inst_Addr, 32'd8);
                    Run = 1'b0;
                end
            end
        end
        chk("b2b_done_count", 32'(n_done), 32'd2);

        for (int k = 0; k < 5; k++) begin
            @(negedge Clka);
            chk("idle_pc", Inst_Addr, 32'd8);
            chk("idle_pulses", {29'd0, Inst_Done, Illegal, Write_Reg}, 32'd0);
        end
        #1;

        // Overflow suppresses the write; addu wraps
        set_reg(5'd1, 32'h7FFF_FFFF);
        set_reg(5'd2, 32'd1);
        run_one(32'h0022_1820, d, il, wd, w, z, o, wa);
        chk("ovf_done", 32'(d), 32'd1);
        chk("ovf_of", 32'(o), 32'd1);
        chk("ovf_wr", 32'(w), 32'd0);
        run_one(32'h0022_1821, d, il, wd, w, z, o, wa);
        chk("addu_wdata", wd, 32'h8000_0000);
        chk("addu_wr_of", {30'd0, w, o}, 32'd2);

        set_reg(5'd1, 32'hFFFF_FFFF);
        run_one(32'h0022_202A, d, il, wd, w, z, o, wa);
        chk("slt_wdata", wd, 32'd1);
        run_one(32'h0022_202B, d, il, wd, w, z, o, wa);
        chk("sltu_wdata", wd, 32'd0);
        chk("sltu_zf", 32'(z), 32'd1);
        run_one(32'h0001_2903, d, il, wd, w, z, o, wa);
        chk("sra_wdata", wd, 32'hFFFF_FFFF);
        chk("sra_waddr", 32'(wa), 32'd5);

        run_one(32'h8C01_0000, d, il, wd, w, z, o, wa);
        chk("lw_illegal", 32'(il), 32'd1);
        chk("lw_no_write", 32'(w), 32'd0);
        run_one(32'h0022_0020, d, il, wd, w, z, o, wa);
        chk("rd0_done", 32'(d), 32'd1);
        chk("rd0_wr", 32'(w), 32'd0);

        // Reset during EX of an add
        rom[m_pc[7:2]] = 32'h0022_1820;
        Run = 1'b1;
        @(posedge Clka);
        #1 Run = 1'b0;
        @(posedge Clka);
        #2 Reset = 1'b1;
        #1;
        chk("rst_ex_pc", Inst_Addr, 32'd0);
        chk("rst_ex_wdata", W_Data, 32'd0);
        chk("rst_ex_pulses", {27'd0, Write_Reg, ZF, OF, Illegal, Inst_Done}, 32'd0);
        @(posedge Clka);
        #2 Reset = 1'b0;
        wr_pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clka);
            if (Write_Reg) wr_pulses++;
        end
        chk("rst_no_write", 32'(wr_pulses), 32'd0);
        #1;

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) set_reg(5'($urandom_range(1, 7)), pick_val());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge Clka);
                #1;
            end
            run_one(rand_inst(), d, il, wd, w, z, o, wa);
        end

        for (int r = 0; r < 32; r++) chk("final_regs", rf[r], mregs[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
